// File: rtl/m2_pkg.sv
// Shared definitions for the M2 Manchester transmit path: scheduler state
// encodings, frame headers used by the encoder, and frame timing constants.
package m2_pkg;

   // One-hot scheduler states.
   typedef enum logic [3:0] {
      ST_DRAIN = 4'b0001,
      ST_IDLE  = 4'b0010,
      ST_WRITE = 4'b0100,
      ST_DONE  = 4'b1000
   } state_e;

   // Sync headers the encoder prepends to command and data words.
   localparam logic [5:0] CMD_HEAD  = 6'b111000;
   localparam logic [5:0] DATA_HEAD = 6'b000111;

   // One serialized frame in bit-clock cycles, plus the encoder's return-to-idle time.
   localparam int FRAME_BITS     = 40;
   localparam int ENC_OVERHEAD   = 8;
   localparam int GAP_CYCLES_DEF = FRAME_BITS + ENC_OVERHEAD;

   // Width of a binary index into n items; never zero.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: the first set request at or above ptr,
// wrapping around, reported both one-hot and as a binary index.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   // Walk the requesters starting at ptr and keep the first hit.
   always_comb begin : search
      int j;
      // NOTE: every output gets a default before the search so no latch is inferred.
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      j     = 0;
      for (int i = 0; i < N_REQ; i++) begin
         j = (int'(ptr) + i) % N_REQ;
         if (!valid && req[j]) begin
            gnt[j] = 1'b1;
            idx    = IDX_W'(j);
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/m2_tx_scheduler.sv
// Round-robin scheduler sharing the M2 encoder FIFO among N_REQ requesters.
// Each grant writes one command word plus 0..2^LEN_W-1 data words back to back,
// then waits for GAP_CYCLES consecutive empty cycles so the encoder is idle
// and frames the next message's first word with the command header.
module m2_tx_scheduler
   import m2_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int LEN_W      = 4,
   parameter int GAP_CYCLES = GAP_CYCLES_DEF,
   parameter int GAP_W      = 6
) (
   input  logic                   clock_41p766k,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*LEN_W-1:0] req_len,
   input  logic [N_REQ*16-1:0]    req_word,
   output logic [N_REQ-1:0]       grant,
   output logic [LEN_W-1:0]       word_idx,
   output logic [N_REQ-1:0]       done,
   output logic [15:0]            fifo_din,
   output logic                   fifo_wr_en,
   input  logic                   fifo_full,
   input  logic                   fifo_empty,
   output logic                   busy
);

   localparam int IDX_W = idx_width(N_REQ);

   state_e             state_q,    state_d;
   logic [N_REQ-1:0]   grant_q,    grant_d;
   logic [IDX_W-1:0]   gnt_idx_q,  gnt_idx_d;
   logic [LEN_W-1:0]   word_idx_q, word_idx_d;
   logic [N_REQ-1:0]   done_q,     done_d;
   logic [LEN_W-1:0]   len_q,      len_d;
   logic [GAP_W-1:0]   gap_cnt_q,  gap_cnt_d;
   logic [IDX_W-1:0]   rr_ptr_q,   rr_ptr_d;

   logic [N_REQ-1:0]   arb_gnt;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_valid;
   logic               wr_fire;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req   (req),
      .ptr   (rr_ptr_q),
      .gnt   (arb_gnt),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   // A word is written whenever the owner is in WRITE and the FIFO has room.
   assign wr_fire    = (state_q == ST_WRITE) && !fifo_full;
   assign fifo_wr_en = wr_fire && !rst;
   assign fifo_din   = req_word[int'(gnt_idx_q)*16 +: 16];
   assign grant      = grant_q;
   assign word_idx   = word_idx_q;
   assign done       = done_q;
   assign busy       = (state_q != ST_IDLE);

   // Next-state logic: drain hold-off, arbitration, word sequencing, completion.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      gnt_idx_d  = gnt_idx_q;
      word_idx_d = word_idx_q;
      done_d     = '0;
      len_d      = len_q;
      gap_cnt_d  = gap_cnt_q;
      rr_ptr_d   = rr_ptr_q;

      unique case (state_q)
         ST_DRAIN: begin
            if (fifo_empty) begin
               if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                  state_d   = ST_IDLE;
                  gap_cnt_d = '0;
               end else begin
                  gap_cnt_d = gap_cnt_q + 1'b1;
               end
            end else begin
               gap_cnt_d = '0;
            end
         end

         ST_IDLE: begin
            if (arb_valid) begin
               grant_d    = arb_gnt;
               gnt_idx_d  = arb_idx;
               len_d      = req_len[int'(arb_idx)*LEN_W +: LEN_W];
               word_idx_d = '0;
               state_d    = ST_WRITE;
            end
         end

         ST_WRITE: begin
            if (wr_fire) begin
               if (word_idx_q == len_q) begin
                  state_d    = ST_DONE;
                  done_d     = grant_q;
                  grant_d    = '0;
                  word_idx_d = '0;
                  rr_ptr_d   = (gnt_idx_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
               end else begin
                  word_idx_d = word_idx_q + 1'b1;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_DRAIN;
         end

         default: begin
            state_d = ST_DRAIN;
         end
      endcase
   end

   // State registers with synchronous reset into the drain hold-off.
   always_ff @(posedge clock_41p766k) begin
      // NOTE: non-blocking assignments so every flop updates from the same pre-edge values.
      if (rst) begin
         state_q    <= ST_DRAIN;
         grant_q    <= '0;
         gnt_idx_q  <= '0;
         word_idx_q <= '0;
         done_q     <= '0;
         len_q      <= '0;
         gap_cnt_q  <= '0;
         rr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         gnt_idx_q  <= gnt_idx_d;
         word_idx_q <= word_idx_d;
         done_q     <= done_d;
         len_q      <= len_d;
         gap_cnt_q  <= gap_cnt_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

endmodule

// File: tb/tb_m2_tx_scheduler.sv
// Self-checking bench for m2_tx_scheduler: a message-level reference model,
// a simple draining FIFO, and directed plus randomized requester traffic.
module tb_m2_tx_scheduler;

   localparam int N   = 4;
   localparam int LW  = 4;
   localparam int GAP = 48;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req;
   logic [N*LW-1:0] req_len;
   logic [N*16-1:0] req_word;
   logic [N-1:0]    grant;
   logic [LW-1:0]   word_idx;
   logic [N-1:0]    done;
   logic [15:0]     fifo_din;
   logic            fifo_wr_en;
   logic            fifo_full;
   logic            fifo_empty;
   logic            busy;

   always #5 clk = ~clk;

   m2_tx_scheduler #(
      .N_REQ      (N),
      .LEN_W      (LW),
      .GAP_CYCLES (GAP),
      .GAP_W      (6)
   ) dut (
      .clock_41p766k (clk),
      .rst           (rst),
      .req           (req),
      .req_len       (req_len),
      .req_word      (req_word),
      .grant         (grant),
      .word_idx      (word_idx),
      .done          (done),
      .fifo_din      (fifo_din),
      .fifo_wr_en    (fifo_wr_en),
      .fifo_full     (fifo_full),
      .fifo_empty    (fifo_empty),
      .busy          (busy)
   );

   // Requester message storage; words are presented by index combinationally.
   logic [15:0] words [N][16];
   int          lens  [N];

   always_comb begin
      req_word = '0;
      req_len  = '0;
      for (int r = 0; r < N; r++) begin
         req_word[r*16 +: 16] = words[r][word_idx];
         req_len[r*LW +: LW]  = LW'(lens[r]);
      end
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Message-level view: who owns the FIFO, how many words of the message have
   // gone out, whether the post-message quiet period is still running.
   int       m_owner;
   int       m_pos;
   int       m_len;
   bit       m_hold;
   int       m_quiet;
   bit       m_closing;
   int       m_rr;
   logic [N-1:0] m_done;

   task automatic model_reset();
      m_owner   = -1;
      m_pos     = 0;
      m_len     = 0;
      m_hold    = 1'b1;
      m_quiet   = 0;
      m_closing = 1'b0;
      m_rr      = 0;
      m_done    = '0;
   endtask

   task automatic model_step();
      m_done = '0;
      if (rst) begin
         model_reset();
         return;
      end
      if (m_closing) begin
         m_closing = 1'b0;
         m_hold    = 1'b1;
         m_quiet   = 0;
      end else if (m_owner >= 0) begin
         if (!fifo_full) begin
            if (m_pos == m_len) begin
               m_done[m_owner] = 1'b1;
               m_rr      = (m_owner + 1) % N;
               m_owner   = -1;
               m_pos     = 0;
               m_closing = 1'b1;
            end else begin
               m_pos++;
            end
         end
      end else if (m_hold) begin
         if (fifo_empty) begin
            m_quiet++;
            if (m_quiet == GAP) begin
               m_hold  = 1'b0;
               m_quiet = 0;
            end
         end else begin
            m_quiet = 0;
         end
      end else if (req != '0) begin
         for (int k = 0; k < N; k++) begin
            int r;
            r = (m_rr + k) % N;
            if (req[r]) begin
               m_owner = r;
               m_len   = lens[r];
               m_pos   = 0;
               break;
            end
         end
      end
   endtask

   // ---------------- stimulus state ----------------
   int           level;
   int           drain_div;
   bit           wr_seen;
   logic [N-1:0] pending;
   bit           hold_req, rand_mode;
   bit           stall_arm, glitch_arm, rst_arm, rst_fired;
   int           stall_left, rst_left;
   int           glitch_cyc, grant_cyc;
   bit           done_flag;
   logic [N-1:0] prev_grant;
   logic [N-1:0] obs_grants [$];
   logic [15:0]  writes [$];

   task automatic new_msg(input int r, input int len);
      lens[r] = len;
      for (int k = 0; k < 16; k++) words[r][k] = 16'($urandom);
   endtask

   task automatic drive_inputs();
      bit glitch_now;
      for (int r = 0; r < N; r++) begin
         if (done[r]) begin
            pending[r] = 1'b0;
            if (hold_req) begin
               req[r] = 1'b1;
               pending[r] = 1'b1;
            end else begin
               req[r] = 1'b0;
            end
         end
         if (rand_mode && grant[r] && req[r] && $urandom_range(0, 29) == 0) req[r] = 1'b0;
         if (rand_mode && !pending[r] && $urandom_range(0, 24) == 0) begin
            new_msg(r, $urandom_range(0, 15));
            req[r] = 1'b1;
            pending[r] = 1'b1;
         end
      end
      if (stall_arm && m_owner >= 0 && m_pos == 1) begin
         stall_left = 5;
         stall_arm  = 1'b0;
      end
      fifo_full = (stall_left > 0) || (rand_mode && $urandom_range(0, 9) == 0) || (level >= 20);
      if (stall_left > 0) stall_left--;
      glitch_now = glitch_arm && m_hold && !m_closing && m_quiet == 30;
      if (glitch_now) begin
         glitch_arm = 1'b0;
         glitch_cyc = cyc;
      end
      fifo_empty = (level == 0) && !glitch_now;
      if (rst_arm && m_owner >= 0 && m_pos == 2) begin
         rst_left  = 1;
         rst_arm   = 1'b0;
         rst_fired = 1'b1;
      end
      rst = (rst_left > 0);
      if (rst_left > 0) rst_left--;
   endtask

   // One clock: account for the FIFO, step the model, compare, drive, compare outputs.
   task automatic tick();
      logic [N-1:0] exp_grant;
      bit exp_wr;
      @(negedge clk);
      cyc++;
      if (wr_seen) level++;
      if (drain_div == 5) begin
         drain_div = 0;
         if (level > 0) level--;
      end else begin
         drain_div++;
      end
      model_step();
      exp_grant = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      check("grant", grant, exp_grant);
      check("word_idx", word_idx, m_pos);
      check("done", done, m_done);
      check("busy", busy, (m_hold || m_owner >= 0 || m_closing));
      if (done != '0) done_flag = 1'b1;
      if (grant != '0 && prev_grant == '0) begin
         obs_grants.push_back(grant);
         grant_cyc = cyc;
      end
      prev_grant = grant;
      drive_inputs();
      #1;
      exp_wr = !rst && m_owner >= 0 && !fifo_full;
      check("fifo_wr_en", fifo_wr_en, exp_wr);
      if (exp_wr) check("fifo_din", fifo_din, words[m_owner][m_pos]);
      wr_seen = fifo_wr_en;
      if (fifo_wr_en) writes.push_back(fifo_din);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic run_until_done(input string tag, input int budget);
      int b;
      b = 0;
      done_flag = 1'b0;
      while (!done_flag && b < budget) begin
         tick();
         b++;
      end
      if (!done_flag) check({tag, "_timeout"}, 0, 1);
   endtask

   task automatic run_until_clear(input string tag, input int budget);
      int b;
      b = 0;
      while (pending != '0 && b < budget) begin
         tick();
         b++;
      end
      if (pending != '0) check({tag, "_timeout"}, 32'(pending), 0);
   endtask

   task automatic do_reset(input int n);
      rst_left = n;
      run(n + 1);
      req = '0;
      pending = '0;
   endtask

   initial begin
      logic [N-1:0] exp_order [5];
      int b;
      exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

      rst = 1'b1; req = '0; fifo_full = 1'b0; fifo_empty = 1'b1;
      level = 0; drain_div = 0; wr_seen = 1'b0; pending = '0;
      hold_req = 1'b0; rand_mode = 1'b0; stall_arm = 1'b0; glitch_arm = 1'b0;
      rst_arm = 1'b0; rst_fired = 1'b0; stall_left = 0; rst_left = 2;
      glitch_cyc = 0; grant_cyc = 0; done_flag = 1'b0; prev_grant = '0;
      for (int r = 0; r < N; r++) new_msg(r, 0);
      model_reset();

      // Reset state.
      run(3);
      check("reset_busy", busy, 1);
      check("reset_grant", grant, 0);
      check("reset_done", done, 0);

      // Single request, three words.
      words[0][0] = 16'h1234; words[0][1] = 16'hAAAA; words[0][2] = 16'h5555;
      lens[0] = 2; req = 4'b0001; pending = 4'b0001;
      writes.delete();
      run_until_done("single", 300);
      check("single_nwrites", writes.size(), 3);
      if (writes.size() == 3) begin
         check("single_w0", writes[0], 16'h1234);
         check("single_w1", writes[1], 16'hAAAA);
         check("single_w2", writes[2], 16'h5555);
      end
      run(120);

      // Round-robin fairness from a fresh pointer, len=0 each.
      do_reset(1);
      for (int r = 0; r < N; r++) new_msg(r, 0);
      req = 4'b1111; pending = 4'b1111; hold_req = 1'b1;
      obs_grants.delete(); writes.delete();
      b = 0;
      while (obs_grants.size() < 5 && b < 800) begin
         tick();
         b++;
      end
      check("rr_ngrants", obs_grants.size(), 5);
      for (int i = 0; i < 5 && i < obs_grants.size(); i++)
         check($sformatf("rr_order%0d", i), obs_grants[i], exp_order[i]);
      check("rr_nwrites", writes.size(), 5);
      hold_req = 1'b0;
      run_until_clear("rr_drain", 400);
      run(150);

      // Backpressure: five stalled cycles after the first write.
      new_msg(2, 3); req = 4'b0100; pending = 4'b0100; stall_arm = 1'b1;
      writes.delete();
      run_until_done("stall", 400);
      check("stall_nwrites", writes.size(), 4);
      for (int k = 0; k < 4 && k < writes.size(); k++)
         check($sformatf("stall_w%0d", k), writes[k], words[2][k]);

      // Gap enforcement: an empty glitch at count 30 restarts the hold-off.
      new_msg(1, 1); req = 4'b0010; pending = 4'b0010; glitch_arm = 1'b1;
      obs_grants.delete();
      run_until_done("gap", 400);
      check("gap_glitch_seen", glitch_arm, 0);
      check("gap_wait", grant_cyc - glitch_cyc, 50);
      run(150);

      // Reset while word 2 of a five-data-word message is being written.
      new_msg(1, 5); req = 4'b0010; pending = 4'b0010; rst_arm = 1'b1;
      b = 0;
      while (!rst_fired && b < 400) begin
         tick();
         b++;
      end
      check("rst_fired", rst_fired, 1);
      tick();
      check("rst_grant", grant, 0);
      check("rst_done", done, 0);
      check("rst_wr_en", fifo_wr_en, 0);
      new_msg(0, 1); req = 4'b0011; pending = 4'b0011;
      obs_grants.delete();
      run_until_clear("rst_resume", 800);
      check("rst_first_grant", (obs_grants.size() > 0) ? 32'(obs_grants[0]) : 32'hFFFF, 4'b0001);
      run(150);

      // Longest message: sixteen words.
      new_msg(3, 15); req = 4'b1000; pending = 4'b1000;
      writes.delete();
      run_until_done("len15", 500);
      check("len15_nwrites", writes.size(), 16);
      for (int k = 0; k < 16 && k < writes.size(); k++)
         check($sformatf("len15_w%0d", k), writes[k], words[3][k]);
      run(150);

      // Random traffic with drops, stalls and FIFO occupancy.
      rand_mode = 1'b1;
      run(3000);
      rand_mode = 1'b0;
      run_until_clear("random_drain", 3000);
      run(20);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
